// File: rtl/lif_spike_rate_meter.sv
// lif_spike_rate_meter
//
// Measures the firing rate of the adaptive LIF neuron by counting rising
// edges of its spike output over a programmable window of clock cycles.
// Windows run back-to-back once started. Each completed window latches one
// saturating count, raises a one-cycle valid strobe and reports whether the
// count saturated.
//
// Optional build macro: LIF_RATE_ISI_EN
//   When defined, adds an inter-spike-interval measurement (isi_out /
//   isi_valid). When undefined, those ports and their logic do not exist.
//
// Ports:
//   clk         design clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   ena         global enable; low freezes all state and masks valid strobes
//   spike_in    spike level from the neuron; a rising edge is one spike
//   start       pulse; arms continuous measurement from IDLE
//   stop        pulse; aborts measurement and returns to IDLE
//   win_len     window length in cycles, sampled at each window start (0 -> 1)
//   rate_out    spike count of the last completed window
//   rate_valid  one-cycle pulse when rate_out updates
//   overflow    completed window saturated; held until the next rate_valid
//   busy        high while measuring (RUN)
//   isi_out     (LIF_RATE_ISI_EN) cycles between the two most recent spikes
//   isi_valid   (LIF_RATE_ISI_EN) one-cycle pulse when isi_out updates

module lif_spike_rate_meter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overflow,
  output logic             busy
`ifdef LIF_RATE_ISI_EN
  ,
  output logic [WIN_W-1:0] isi_out,
  output logic             isi_valid
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             spike_q;
  logic             spike_edge;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             sat_flag;
  logic             sat_now;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_reload;
  logic             win_end;
  logic             run_go;
  logic             valid_pend;

  // An edge arriving while the counter already sits at its ceiling is the
  // event that marks the window as saturated.
  always_comb begin
    spike_edge = spike_in & ~spike_q;
    win_reload = (win_len == '0) ? WIN_ONE : win_len;
    sat_now    = spike_edge && (count == CNT_MAX);
    count_nxt  = sat_now ? count : count + CNT_W'(spike_edge);
    win_end    = (state == RUN) && (win_cnt == WIN_ONE);
    run_go     = (state == IDLE) && start && !stop;
  end

  // Next-state logic; every transition needs ena. stop in RUN wins even in
  // the window-end cycle, where the datapath still completes the window.
  always_comb begin
    state_nxt = state;
    busy      = (state == RUN);
    if (ena) begin
      if (run_go) begin
        state_nxt = RUN;
      end else if ((state == RUN) && stop) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Window datapath. The window-end cycle latches the result and reloads
  // the next window on the same edge, so windows abut without a gap. A
  // valid strobe earned just before ena drops is kept in valid_pend and is
  // only shown once ena returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q    <= 1'b0;
      count      <= '0;
      sat_flag   <= 1'b0;
      win_cnt    <= '0;
      rate_out   <= '0;
      overflow   <= 1'b0;
      valid_pend <= 1'b0;
    end else if (ena) begin
      spike_q    <= spike_in;
      valid_pend <= win_end;
      if (run_go) begin
        win_cnt  <= win_reload;
        count    <= '0;
        sat_flag <= 1'b0;
      end else if (state == RUN) begin
        if (win_end) begin
          rate_out <= count_nxt;
          overflow <= sat_flag | sat_now;
          win_cnt  <= win_reload;
          count    <= '0;
          sat_flag <= 1'b0;
        end else begin
          count    <= count_nxt;
          win_cnt  <= win_cnt - WIN_ONE;
          sat_flag <= sat_flag | sat_now;
        end
      end
    end
  end

  assign rate_valid = valid_pend & ena;

`ifdef LIF_RATE_ISI_EN
  localparam logic [WIN_W-1:0] ISI_MAX = '1;

  logic [WIN_W-1:0] isi_cnt;
  logic             isi_armed;
  logic             isi_pend;

  // Interval counter: restarts on every spike. The first spike of a run only
  // arms it; each later spike reports the elapsed cycles including its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_pend  <= 1'b0;
      isi_out   <= '0;
    end else if (ena) begin
      isi_pend <= 1'b0;
      if (run_go) begin
        isi_cnt   <= '0;
        isi_armed <= 1'b0;
      end else if (state == RUN) begin
        if (spike_edge) begin
          isi_cnt   <= '0;
          isi_armed <= 1'b1;
          if (isi_armed) begin
            isi_out  <= (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + WIN_ONE;
            isi_pend <= 1'b1;
          end
        end else if (isi_cnt != ISI_MAX) begin
          isi_cnt <= isi_cnt + WIN_ONE;
        end
      end
    end
  end

  assign isi_valid = isi_pend & ena;
`endif

endmodule

// File: tb/tb_lif_spike_rate_meter.sv
// tb_lif_spike_rate_meter
//
// Directed testbench for lif_spike_rate_meter with hand-computed expected
// values. Each scenario task drives its own stimulus and checks inline.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_lif_spike_rate_meter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        spike_in;
  logic        start;
  logic        stop;
  logic [15:0] win_len;
  logic [7:0]  rate_out;
  logic        rate_valid;
  logic        overflow;
  logic        busy;
`ifdef LIF_RATE_ISI_EN
  logic [15:0] isi_out;
  logic        isi_valid;
`endif

  int total;
  int bad;

  lif_spike_rate_meter #(
    .CNT_W(8),
    .WIN_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .start     (start),
    .stop      (stop),
    .win_len   (win_len),
    .rate_out  (rate_out),
    .rate_valid(rate_valid),
    .overflow  (overflow),
    .busy      (busy)
`ifdef LIF_RATE_ISI_EN
    ,
    .isi_out   (isi_out),
    .isi_valid (isi_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] len);
    win_len  = len;
    spike_in = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic stop_run();
    spike_in = 1'b0;
    stop     = 1'b1;
    tick();
    stop     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (rate_out !== 8'd0) begin bad++; $display("[TB] FAIL reset_rate: got %0d want 0", rate_out); end
    total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", rate_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      spike_in = (k % 2 == 1);
      tick();
      total++; if (rate_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_quiet: got valid=%b busy=%b want 0 0", rate_valid, busy); end
    end
    total++; if (rate_out !== 8'd0) begin bad++; $display("[TB] FAIL idle_rate: got %0d want 0", rate_out); end
  endtask

  task automatic test_basic_window();
    start_run(16'd10);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
    for (int k = 1; k <= 10; k++) begin
      spike_in = (k == 2 || k == 5 || k == 9);
      tick();
      if (k < 10) begin
        total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid: cycle %0d got %b want 0", k, rate_valid); end
      end
    end
    total++; if (rate_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid: got %b want 1", rate_valid); end
    total++; if (rate_out !== 8'd3) begin bad++; $display("[TB] FAIL basic_rate: got %0d want 3", rate_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL basic_ovf: got %b want 0", overflow); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_end: got %b want 1", busy); end
    for (int k = 11; k <= 20; k++) begin
      spike_in = 1'b0;
      tick();
      if (k == 11) begin
        total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse_width: got %b want 0", rate_valid); end
      end
    end
    total++; if (rate_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid2: got %b want 1", rate_valid); end
    total++; if (rate_out !== 8'd0) begin bad++; $display("[TB] FAIL basic_rate2: got %0d want 0", rate_out); end
    stop_run();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_saturation();
    start_run(16'd300);
    for (int k = 1; k <= 900; k++) begin
      spike_in = (k % 2 == 1);
      if (k == 2) win_len = 16'd600;
      tick();
      if (k == 300) begin
        total++; if (rate_valid !== 1'b1 || rate_out !== 8'd150 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL sat_first: got v=%b rate=%0d ovf=%b want 1 150 0", rate_valid, rate_out, overflow); end
      end
      if (k == 900) begin
        total++; if (rate_valid !== 1'b1 || rate_out !== 8'd255 || overflow !== 1'b1) begin bad++; $display("[TB] FAIL sat_second: got v=%b rate=%0d ovf=%b want 1 255 1", rate_valid, rate_out, overflow); end
      end
    end
    stop_run();
    total++; if (overflow !== 1'b1 || rate_out !== 8'd255) begin bad++; $display("[TB] FAIL sat_hold: got ovf=%b rate=%0d want 1 255", overflow, rate_out); end
  endtask

  task automatic test_held_spike();
    start_run(16'd100);
    for (int k = 1; k <= 100; k++) begin
      spike_in = (k <= 50);
      tick();
    end
    total++; if (rate_valid !== 1'b1 || rate_out !== 8'd1) begin bad++; $display("[TB] FAIL held_rate: got v=%b rate=%0d want 1 1", rate_valid, rate_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL held_ovf_clear: got %b want 0", overflow); end
    stop_run();
  endtask

  task automatic test_min_window();
    start_run(16'd0);
    for (int k = 1; k <= 6; k++) begin
      spike_in = (k % 2 == 1);
      tick();
      total++; if (rate_valid !== 1'b1) begin bad++; $display("[TB] FAIL minwin_valid: cycle %0d got %b want 1", k, rate_valid); end
      total++; if (rate_out !== ((k % 2 == 1) ? 8'd1 : 8'd0)) begin bad++; $display("[TB] FAIL minwin_rate: cycle %0d got %0d want %0d", k, rate_out, k % 2); end
    end
    spike_in = 1'b1;
    stop     = 1'b1;
    tick();
    stop     = 1'b0;
    spike_in = 1'b0;
    total++; if (rate_valid !== 1'b1 || rate_out !== 8'd1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL stop_at_end: got v=%b rate=%0d busy=%b want 1 1 0", rate_valid, rate_out, busy); end
    tick();
    total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL stop_at_end_after: got %b want 0", rate_valid); end
  endtask

  task automatic test_stop_abort();
    start_run(16'd10);
    for (int k = 1; k <= 10; k++) begin
      spike_in = (k == 1 || k == 3 || k == 5 || k == 7);
      tick();
    end
    total++; if (rate_valid !== 1'b1 || rate_out !== 8'd4) begin bad++; $display("[TB] FAIL abort_prior: got v=%b rate=%0d want 1 4", rate_valid, rate_out); end
    for (int k = 11; k <= 14; k++) begin
      spike_in = (k == 12);
      tick();
    end
    stop_run();
    total++; if (busy !== 1'b0 || rate_valid !== 1'b0 || rate_out !== 8'd4) begin bad++; $display("[TB] FAIL abort_state: got busy=%b v=%b rate=%0d want 0 0 4", busy, rate_valid, rate_out); end
    for (int k = 0; k < 12; k++) begin
      tick();
      total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_valid: got %b want 0", rate_valid); end
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL start_stop_idle: got %b want 0", busy); end
    tick();
    tick();
    total++; if (busy !== 1'b0 || rate_out !== 8'd4) begin bad++; $display("[TB] FAIL start_stop_hold: got busy=%b rate=%0d want 0 4", busy, rate_out); end
  endtask

  task automatic test_enable_freeze();
    start_run(16'd4);
    spike_in = 1'b1;
    tick();
    ena = 1'b0;
    spike_in = 1'b0; tick();
    spike_in = 1'b1; tick();
    spike_in = 1'b0; tick();
    total++; if (busy !== 1'b1 || rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL ena_freeze: got busy=%b v=%b want 1 0", busy, rate_valid); end
    ena = 1'b1;
    spike_in = 1'b0; tick();
    spike_in = 1'b1; tick();
    spike_in = 1'b0; tick();
    ena = 1'b0;
    #1;
    total++; if (rate_valid !== 1'b0 || rate_out !== 8'd2) begin bad++; $display("[TB] FAIL ena_masked: got v=%b rate=%0d want 0 2", rate_valid, rate_out); end
    tick();
    tick();
    total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL ena_still_masked: got %b want 0", rate_valid); end
    ena = 1'b1;
    #1;
    total++; if (rate_valid !== 1'b1) begin bad++; $display("[TB] FAIL ena_delayed_valid: got %b want 1", rate_valid); end
    tick();
    total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL ena_valid_once: got %b want 0", rate_valid); end
    stop_run();
  endtask

`ifdef LIF_RATE_ISI_EN
  task automatic test_isi();
    start_run(16'd100);
    for (int k = 1; k <= 14; k++) begin
      spike_in = (k == 3 || k == 10 || k == 14);
      tick();
      if (k == 3) begin
        total++; if (isi_valid !== 1'b0) begin bad++; $display("[TB] FAIL isi_first: got %b want 0", isi_valid); end
      end
      if (k == 10) begin
        total++; if (isi_valid !== 1'b1 || isi_out !== 16'd7) begin bad++; $display("[TB] FAIL isi_a: got v=%b isi=%0d want 1 7", isi_valid, isi_out); end
      end
      if (k == 11) begin
        total++; if (isi_valid !== 1'b0) begin bad++; $display("[TB] FAIL isi_pulse: got %b want 0", isi_valid); end
      end
      if (k == 14) begin
        total++; if (isi_valid !== 1'b1 || isi_out !== 16'd4) begin bad++; $display("[TB] FAIL isi_b: got v=%b isi=%0d want 1 4", isi_valid, isi_out); end
      end
    end
    stop_run();
  endtask
`endif

  task automatic test_reset_mid_window();
    start_run(16'd10);
    for (int k = 1; k <= 5; k++) begin
      spike_in = (k == 1 || k == 3);
      tick();
    end
    rst_n = 1'b0;
    tick();
    total++; if (rate_out !== 8'd0 || rate_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset: got rate=%0d v=%b ovf=%b busy=%b want 0 0 0 0", rate_out, rate_valid, overflow, busy); end
`ifdef LIF_RATE_ISI_EN
    total++; if (isi_out !== 16'd0 || isi_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_isi: got isi=%0d v=%b want 0 0", isi_out, isi_valid); end
`endif
    rst_n = 1'b1;
    spike_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++; if (rate_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_quiet: got v=%b busy=%b want 0 0", rate_valid, busy); end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    spike_in = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    win_len  = 16'd0;
    test_reset();
    test_basic_window();
    test_saturation();
    test_held_spike();
    test_min_window();
    test_stop_abort();
    test_enable_freeze();
`ifdef LIF_RATE_ISI_EN
    test_isi();
`endif
    test_reset_mid_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_spike_rate_meter.md
Name: lif_spike_rate_meter

Overview:
- Downstream stage of the adaptive LIF neuron: consumes the neuron's spike output and measures firing rate over a programmable window of clock cycles.
- Latches one spike count per window, with a one-cycle valid strobe and a per-window overflow flag.
- The count drives the top-level display/readout path (uo_out / segment decoder) so the neuron's adaptation can be observed on silicon.

Parameters:
- CNT_W, 8: width of the spike counter and rate_out; the count saturates at 2^CNT_W-1.
- WIN_W, 16: width of win_len and of the internal window down-counter.

Ports:
- clk  input  1  design clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  global enable; when low, all internal state holds and rate_valid is 0.
- spike_in  input  1  spike level from the LIF neuron; a rising edge is one spike.
- start  input  1  single-cycle pulse; arms continuous measurement from IDLE.
- stop  input  1  single-cycle pulse; aborts measurement and returns to IDLE.
- win_len  input  WIN_W  window length in cycles; sampled at each window start; 0 is treated as 1.
- rate_out  output  CNT_W  spike count of the last completed window; held until the next window completes.
- rate_valid  output  1  one-cycle pulse when rate_out updates.
- overflow  output  1  set together with rate_valid when the completed window saturated; held until the next rate_valid.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - rate_out=0, rate_valid=0, overflow=0, busy=0.
  - Internal count=0, win_cnt=0, spike_q=0.
  - Reset mid-window discards the partial count; no rate_valid is produced.
- Edge detect:
  - spike_q registers spike_in every enabled cycle.
  - edge = spike_in & ~spike_q.
  - A spike_in held high counts once.
  - spike_in high on the first enabled cycle after reset counts as an edge.
- FSM, two states (IDLE, RUN). All transitions require ena=1.
  - IDLE to RUN on start=1 and stop=0: win_cnt <= max(win_len,1); count <= 0; busy=1 from the next cycle.
  - In IDLE, edges are ignored; spike_q still tracks spike_in.
  - In RUN, each enabled cycle: count <= sat(count + edge); win_cnt <= win_cnt - 1.
  - Window end, when win_cnt==1 in RUN:
    - rate_out <= sat(count + edge); overflow <= saturation occurred in this window (including this cycle).
    - rate_valid=1 in the following cycle only.
    - Same edge: win_cnt reloads max(win_len,1) and count <= 0, so windows are back-to-back with no gap cycle.
  - A window of length N therefore covers exactly N enabled cycles.
  - RUN to IDLE on stop=1, effective that edge. The partial window is discarded; rate_out and overflow keep their previous values.
  - stop in the window-end cycle: the window completes (rate_valid asserted), then the block goes to IDLE.
  - start while in RUN is ignored.
  - start and stop together in IDLE: stop wins and the block stays IDLE.
- Saturation:
  - count never wraps; it holds at 2^CNT_W-1 and an internal sat flag is set.
  - The sat flag clears at each window reload.
- ena=0:
  - Counters, FSM and spike_q freeze; edges during ena=0 are lost.
  - A pending rate_valid pulse is delayed until the first cycle ena=1 again.
- Latency: from the last cycle of the window to rate_valid/rate_out update is 1 cycle.

Optional Feature:
- Macro: LIF_RATE_ISI_EN.
- When defined:
  - Adds output isi_out [WIN_W-1:0] and output isi_valid [1].
  - A free-running interval counter runs in RUN, saturating at 2^WIN_W-1, and resets to 0 on each edge.
  - On the 2nd and later edges within a run, isi_out <= counter value + 1, and isi_valid pulses 1 cycle later.
  - The first edge after IDLE to RUN only starts the counter.
  - isi_out resets to 0.
- When undefined: these ports and the interval logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 20 cycles with spike_in toggling -> rate_out=0, rate_valid never asserted, busy=0.
- win_len=10, start, spike_in pulses (1-cycle high) on RUN cycles 2, 5, 9 -> rate_valid 1 cycle after cycle 10 with rate_out=3; next window starts immediately; with no further spikes the next result is 0.
- win_len=300, CNT_W=8, spike_in toggling every cycle (150 edges), then win_len=600 (300 edges) -> first result 150, overflow=0; second result 255, overflow=1.
- spike_in held high for 50 cycles in a 100-cycle window -> rate_out=1; win_len=0 with one spike per cycle pulse -> rate_valid every cycle, rate_out=1.
- stop asserted at RUN cycle 5 of a 10-cycle window after a prior result of 4 -> no rate_valid, rate_out stays 4, busy=0; start+stop together in IDLE -> remains IDLE.
- With LIF_RATE_ISI_EN: spikes at RUN cycles 3, 10, 14 -> isi_out=7 then 4, each with isi_valid; rst_n=0 mid-window -> all outputs 0 on the next cycle.
